// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive sequencer.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP,
        ERR
    } rx_state_t;

    // Decoded SYNC pattern (KJKJKJKK), LSB received first.
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Consecutive 1s after which the transmitter inserts a stuffed 0.
    localparam int MAX_ONES = 6;

endpackage

// File: rtl/usb_rx_sequencer_if.sv
// Edge/EOP detector and decode-stage inputs plus RX FIFO-side outputs of the sequencer.
interface usb_rx_sequencer_if;
    logic       d_edge;
    logic       eop;
    logic       d_orig;
    logic       shift_enable;
    logic       rcving;
    logic       byte_received;
    logic [7:0] rx_data;
    logic       packet_done;
    logic       r_error;

    // Upstream side: line detectors and decode stage.
    modport master (
        output d_edge, eop, d_orig,
        input  shift_enable, rcving, byte_received, rx_data, packet_done, r_error
    );

    // The sequencer itself.
    modport slave (
        input  d_edge, eop, d_orig,
        output shift_enable, rcving, byte_received, rx_data, packet_done, r_error
    );
endinterface

// File: rtl/rx_bit_timer.sv
// Bit-period counter resynchronised by D+ edges; produces the mid-bit sample strobe.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic run,       // counter free-runs only while a packet is active
    input  logic resync,    // D+ edge: restart the bit period
    input  logic sample_en, // strobe allowed (SYNC or DATA)
    output logic sample
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PHASE = CW'(SAMPLE_PHASE);

    logic [CW-1:0] bit_cnt;

    // Wrap counter; an edge (or being idle) pins it to zero so the next bit starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  bit_cnt <= '0;
        else if (resync || !run)  bit_cnt <= '0;
        else if (bit_cnt == LAST) bit_cnt <= '0;
        else                      bit_cnt <= bit_cnt + 1'b1;
    end

    // An edge landing on the sample point wins: the stale sample is skipped.
    assign sample = sample_en && (bit_cnt == PHASE) && !resync;

endmodule

// File: rtl/usb_rx_sequencer.sv
// USB RX sequencer: bit timing, SYNC check, destuffing, byte assembly and framing errors.
module usb_rx_sequencer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input logic               clk,
    input logic               rst,
    usb_rx_sequencer_if.slave bus
);
    rx_state_t  state;
    logic [2:0] ones_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       sample;
    logic       rcving;
    logic       byte_received;
    logic [7:0] rx_data;
    logic       packet_done;
    logic       r_error;

    logic       d;
    logic       stuff_slot;
    logic       byte_done;
    logic [7:0] next_byte;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SAMPLE_PHASE(SAMPLE_PHASE)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (state != IDLE),
        .resync    (bus.d_edge),
        .sample_en (state == SYNC || state == DATA),
        .sample    (sample)
    );

    assign d          = bus.d_orig;
    assign stuff_slot = (ones_cnt == 3'(MAX_ONES));
    assign byte_done  = (bit_idx == 3'd7);
    assign next_byte  = {d, shreg[7:1]};

    // Packet FSM with stuffing and byte assembly; all outputs registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ones_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rcving        <= 1'b0;
            byte_received <= 1'b0;
            rx_data       <= '0;
            packet_done   <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            byte_received <= 1'b0;
            packet_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.d_edge) begin
                        state    <= SYNC;
                        r_error  <= 1'b0;
                        bit_idx  <= '0;
                        shreg    <= '0;
                        ones_cnt <= '0;
                        rcving   <= 1'b1;
                    end
                end
                SYNC, DATA: begin
                    if (sample) begin
                        if (state == DATA && bus.eop) begin
                            // SE0 is only legal on a byte boundary.
                            if (bit_idx == 3'd0) begin
                                state <= EOP;
                            end else begin
                                state   <= ERR;
                                r_error <= 1'b1;
                            end
                        end else if (stuff_slot) begin
                            // Stuff slot: a 0 is dropped silently, a 1 is a violation.
                            if (d) begin
                                state   <= ERR;
                                r_error <= 1'b1;
                            end else begin
                                ones_cnt <= '0;
                            end
                        end else begin
                            ones_cnt <= d ? ones_cnt + 3'd1 : 3'd0;
                            shreg    <= next_byte;
                            bit_idx  <= bit_idx + 3'd1;
                            if (byte_done) begin
                                if (state == SYNC) begin
                                    if (next_byte == SYNC_BYTE) begin
                                        state <= DATA;
                                    end else begin
                                        state   <= ERR;
                                        r_error <= 1'b1;
                                    end
                                end else begin
                                    rx_data       <= next_byte;
                                    byte_received <= 1'b1;
                                end
                            end
                        end
                    end
                end
                EOP: begin
                    if (!bus.eop) begin
                        state       <= IDLE;
                        packet_done <= 1'b1;
                        rcving      <= 1'b0;
                    end
                end
                ERR: begin
                    r_error <= 1'b1;
                    if (!bus.eop) begin
                        state  <= IDLE;
                        rcving <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.shift_enable  = sample;
    assign bus.rcving        = rcving;
    assign bus.byte_received = byte_received;
    assign bus.rx_data       = rx_data;
    assign bus.packet_done   = packet_done;
    assign bus.r_error       = r_error;

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Scoreboard bench: packets are built as byte lists, serialised with bit stuffing and
// jittered bit periods; a monitor pops expected events as the DUT reports them.
module tb_usb_rx_sequencer;
    localparam int C  = 8;
    localparam int SP = 3;
    localparam int EV_BYTE = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_rx_sequencer_if bus();

    usb_rx_sequencer #(.CLKS_PER_BIT(C), .SAMPLE_PHASE(SP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ev_t  exp_q[$];
    logic wire_q[$];
    int   ones;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_ev(input int kind, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h, expected none", kind, d);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (e.kind == EV_BYTE && kind == EV_BYTE) check("rx_data", int'(d), int'(e.data));
        end
    endtask

    // Transmitter-side stuffing: a 0 follows every run of six 1s.
    task automatic add_bit(input logic b);
        wire_q.push_back(b);
        if (b) ones++;
        else   ones = 0;
        if (ones == 6) begin
            wire_q.push_back(1'b0);
            ones = 0;
        end
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) add_bit(b[i]);
    endtask

    task automatic start_packet(input logic [7:0] sync);
        wire_q.delete();
        ones = 0;
        add_byte(sync);
    endtask

    task automatic tick(input logic e, input logic d, input logic ep);
        @(posedge clk);
        #1;
        bus.d_edge = e;
        bus.d_orig = d;
        bus.eop    = ep;
    endtask

    // NRZI view: a 0 (or the packet's first bit) starts with an edge. Only bits that end
    // in an edge get +/-1 cycle of drift, so the error never accumulates past a resync.
    task automatic emit();
        logic e;
        logic ne;
        int   len;
        for (int i = 0; i < wire_q.size(); i++) begin
            e   = (i == 0) || !wire_q[i];
            ne  = (i + 1 < wire_q.size()) && !wire_q[i + 1];
            len = ne ? C - 1 + int'($urandom_range(2)) : C;
            for (int k = 0; k < len; k++) begin
                tick(e && k == 0, wire_q[i], 1'b0);
                if (i == 1 && k == 0) check("rcving_active", int'(bus.rcving), 1);
            end
        end
        wire_q.delete();
    endtask

    task automatic finish_packet(input int exp_err);
        for (int k = 0; k < 2 * C; k++) tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3 * C; k++) tick(1'b0, 1'b0, 1'b0);
        check("rcving_idle", int'(bus.rcving), 0);
        check("r_error_after", int'(bus.r_error), exp_err);
    endtask

    task automatic pkt_clean(input logic [7:0] b[$]);
        start_packet(8'h80);
        foreach (b[i]) begin
            add_byte(b[i]);
            push_ev(EV_BYTE, b[i]);
        end
        push_ev(EV_DONE, 8'h00);
        emit();
        finish_packet(0);
    endtask

    // Bytes must end in a 0 so the seven raw 1s start a fresh run.
    task automatic pkt_stuff_err(input logic [7:0] b[$]);
        start_packet(8'h80);
        foreach (b[i]) begin
            add_byte(b[i]);
            push_ev(EV_BYTE, b[i]);
        end
        for (int i = 0; i < 7; i++) wire_q.push_back(1'b1);
        push_ev(EV_ERR, 8'h00);
        emit();
        finish_packet(1);
    endtask

    task automatic pkt_bad_sync(input logic [7:0] s);
        start_packet(s);
        push_ev(EV_ERR, 8'h00);
        emit();
        finish_packet(1);
    endtask

    task automatic pkt_mid_eop(input logic [7:0] b[$], input int p, input logic [7:0] part);
        start_packet(8'h80);
        foreach (b[i]) begin
            add_byte(b[i]);
            push_ev(EV_BYTE, b[i]);
        end
        for (int i = 0; i < p; i++) add_bit(part[i]);
        push_ev(EV_ERR, 8'h00);
        emit();
        finish_packet(1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_shift_enable"}, int'(bus.shift_enable), 0);
        check({tag, "_rcving"}, int'(bus.rcving), 0);
        check({tag, "_byte_received"}, int'(bus.byte_received), 0);
        check({tag, "_rx_data"}, int'(bus.rx_data), 0);
        check({tag, "_packet_done"}, int'(bus.packet_done), 0);
        check({tag, "_r_error"}, int'(bus.r_error), 0);
    endtask

    // Monitor: event scoreboard plus sample-timing check relative to the last edge.
    int   cyc = 0;
    int   last_edge = -1;
    logic prev_err = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            last_edge = -1;
            prev_err  = 1'b0;
        end else begin
            if (bus.shift_enable)
                check("sample_phase",
                      int'(last_edge >= 0 && (cyc - last_edge) >= SP + 1 &&
                           ((cyc - last_edge - SP - 1) % C) == 0), 1);
            if (bus.d_edge) last_edge = cyc;
            if (bus.byte_received) expect_ev(EV_BYTE, bus.rx_data);
            if (bus.packet_done)   expect_ev(EV_DONE, 8'h00);
            if (bus.r_error && !prev_err) expect_ev(EV_ERR, 8'h00);
            prev_err = bus.r_error;
        end
    end

    initial begin
        logic [7:0] bl[$];
        logic [7:0] b;
        int         kind;
        int         n;

        rst        = 1'b1;
        bus.d_edge = 1'b0;
        bus.d_orig = 1'b0;
        bus.eop    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (4) tick(1'b0, 1'b0, 1'b0);

        // Directed cases.
        bl = '{8'hA5, 8'h3C};
        pkt_clean(bl);
        bl = '{8'hFF};
        pkt_clean(bl);
        bl = '{8'h00};
        pkt_stuff_err(bl);
        pkt_bad_sync(8'h81);
        bl = '{8'h12};
        pkt_mid_eop(bl, 5, 8'h1B);

        // Reset in the middle of the second byte: only the first byte may be reported.
        start_packet(8'h80);
        add_byte(8'hA5);
        push_ev(EV_BYTE, 8'hA5);
        add_bit(1'b0);
        add_bit(1'b1);
        add_bit(1'b0);
        emit();
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_outputs_zero("midreset");
        bus.d_edge = 1'b0;
        bus.d_orig = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("midreset_queue", exp_q.size(), 0);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        bl = '{8'h3C};
        pkt_clean(bl);

        // Randomised packets.
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(3);
            n    = $urandom_range(1, 3);
            bl.delete();
            for (int i = 0; i < n; i++) begin
                b = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
                if (kind == 1) b[7] = 1'b0;
                bl.push_back(b);
            end
            case (kind)
                0: pkt_clean(bl);
                1: pkt_stuff_err(bl);
                2: pkt_bad_sync(8'h80 ^ (8'h01 << $urandom_range(6)));
                default: pkt_mid_eop(bl, $urandom_range(1, 7), 8'($urandom));
            endcase
        end

        check("leftover_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
